// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit driving the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dz;

    logic               sgn;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               accept;
    logic               last;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    // Signed ops work on magnitudes; signs are re-applied in FIX.
    assign sgn    = ~op[0];
    assign sa     = sgn & srca[WIDTH-1];
    assign sb     = sgn & srcb[WIDTH-1];
    assign mag_a  = sa ? -srca : srca;
    assign mag_b  = sb ? -srcb : srcb;
    assign accept = start & (state == IDLE);
    assign last   = (count == CW'(WIDTH - 1));

    // Iteration datapath and sign fix-up results.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, b_reg} : '0);
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}
                  - {1'b0, b_reg};
        mul_res   = neg_q ? -acc : acc;
        q_fix     = (neg_q & ~dz) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic and busy flag.
    always_comb begin
        state_n = state;
        busy    = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_n = op[1] ? DIV : MUL;
            end
            MUL, DIV: begin
                if (last) state_n = FIX;
            end
            FIX: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand latches, iteration counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (accept) begin
            count  <= '0;
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= (srcb == '0);
            if (op[1]) begin
                b_reg <= mag_b;
                acc   <= {{WIDTH{1'b0}}, mag_a};
            end else begin
                b_reg <= mag_a;
                acc   <= {{WIDTH{1'b0}}, mag_b};
            end
        end else if (state == MUL) begin
            count <= count + 1'b1;
            acc   <= {mul_sum, acc[WIDTH-1:1]};
        end else if (state == DIV) begin
            count <= count + 1'b1;
            if (!div_trial[WIDTH])
                acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc <= {acc[2*WIDTH-2:0], 1'b0};
        end else if (state == FIX) begin
            count <= '0;
        end
    end

    // HI/LO registers and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                if (is_div) begin
                    hi <= r_fix;
                    lo <= q_fix;
                end else begin
                    hi <= mul_res[2*WIDTH-1:WIDTH];
                    lo <= mul_res[WIDTH-1:0];
                end
            end else if (state == IDLE) begin
                if (mthi) hi <= srca;
                if (mtlo) lo <= srca;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed ops, latency,
// busy/done behaviour, mthi/mtlo and asynchronous reset abort.
module tb_mul_div_unit;

    localparam int W = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         mthi;
    logic         mtlo;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t exp_q[$];

    int n_checks;
    int n_fail;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is compared against the oldest entry.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_hi"}, hi, e.hi);
                check({e.name, "_lo"}, lo, e.lo);
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo);
        exp_t e;
        e.name = name;
        e.hi   = ehi;
        e.lo   = elo;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        srca  = 32'hDEAD_BEEF;
        srcb  = 32'h1234_5678;
        check({name, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string name, input int exp_cyc);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(exp_cyc));
        check({name, "_busy_in_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        srca     = '0;
        srcb     = '0;
        mthi     = 1'b0;
        mtlo     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001);
        wait_done("multu_max", 33);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("hi_stable", hi, 32'hFFFF_FFFE);

        issue("mult_neg", OP_MULT, -32'sd3, 32'sd7,
              32'hFFFF_FFFF, 32'hFFFF_FFEB);
        wait_done("mult_neg", 33);

        issue("div_neg", OP_DIV, -32'sd7, 32'sd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done("div_neg", 33);

        issue("divu_zero", OP_DIVU, 32'd100, 32'd0,
              32'd100, 32'hFFFF_FFFF);
        wait_done("divu_zero", 33);

        issue("div_zero_neg", OP_DIV, -32'sd8, 32'd0,
              32'hFFFF_FFF8, 32'hFFFF_FFFF);
        wait_done("div_zero_neg", 33);

        issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0000_0000, 32'h8000_0000);
        wait_done("div_ovf", 33);

        // Start and mthi mid-operation are ignored.
        issue("divu_9_4", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2);
        repeat (9) @(negedge clk);
        start = 1'b1;
        op    = OP_DIVU;
        srca  = 32'd5;
        srcb  = 32'd6;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("busy_mthi_hi", hi, 32'd0);
        check("busy_mtlo_lo", lo, 32'h8000_0000);
        check("busy_still", 32'(busy), 32'd1);
        wait_done("divu_9_4", 24);

        // Back-to-back: start again during the done cycle.
        issue("b2b_first", OP_MULTU, 32'h0001_0000, 32'h0001_0000,
              32'd1, 32'd0);
        wait_done("b2b_first", 33);
        issue("b2b_second", OP_DIV, 32'd100, -32'sd7,
              32'd2, 32'hFFFF_FFF2);
        wait_done("b2b_second", 33);

        // mthi+mtlo together while idle.
        @(negedge clk);
        mthi = 1'b1;
        mtlo = 1'b1;
        srca = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthilo_hi", hi, 32'hA5A5_A5A5);
        check("mthilo_lo", lo, 32'hA5A5_A5A5);

        // mtlo alone leaves hi untouched.
        @(negedge clk);
        mtlo = 1'b1;
        srca = 32'h0000_1234;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        check("mtlo_hi", hi, 32'hA5A5_A5A5);
        check("mtlo_lo", lo, 32'h0000_1234);

        // Asynchronous reset in the middle of a MULT.
        issue("mult_abort", OP_MULT, -32'sd5, 32'sd9,
              32'hFFFF_FFFF, 32'hFFFF_FFD3);
        repeat (14) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue("after_rst", OP_MULTU, 32'd1000, 32'd1000,
              32'd0, 32'd1_000_000);
        wait_done("after_rst", 33);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
